// File: rtl/fetch_pipe.sv
// fetch_pipe: single-stage instruction fetch with redirect, stall, optional delay slot and saturating event counters.
module fetch_pipe #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 32,
  parameter int RESET_PC    = 0,
  parameter int DELAY_SLOT  = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_EX,
  input  logic [1:0]             pc_src_EX,
  input  logic [PC_WIDTH-1:0]    branch_addr_EX,
  input  logic [PC_WIDTH-1:0]    jtype_addr_EX,
  input  logic [PC_WIDTH-1:0]    reg_addr_EX,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    PC_FETCH,
  output logic [INSTR_WIDTH-1:0] instruction_EX,
  output logic [PC_WIDTH-1:0]    PC_EX,
  output logic                   valid_EX,
  output logic [CNT_WIDTH-1:0]   stall_count,
  output logic [CNT_WIDTH-1:0]   redirect_count
);
  logic [PC_WIDTH-1:0] target;
  always_comb target = pc_src_EX == 2'b01 ? branch_addr_EX :
                       pc_src_EX == 2'b10 ? jtype_addr_EX : reg_addr_EX;
  assign imem_addr = PC_FETCH;
  always_ff @(posedge clk) begin
    if (rst) begin
      PC_FETCH       <= PC_WIDTH'(RESET_PC);
      instruction_EX <= '0;
      PC_EX          <= '0;
      valid_EX       <= 1'b0;
      stall_count    <= '0;
      redirect_count <= '0;
    end else if (pc_src_EX != 2'b00) begin
      PC_FETCH       <= target;
      instruction_EX <= DELAY_SLOT != 0 ? imem_rdata : '0;
      PC_EX          <= PC_FETCH;
      valid_EX       <= DELAY_SLOT != 0;
      if (redirect_count != '1) redirect_count <= redirect_count + 1'b1;
    end else if (stall_EX) begin
      if (stall_count != '1) stall_count <= stall_count + 1'b1;
    end else begin
      PC_FETCH       <= PC_FETCH + 1'b1;
      instruction_EX <= imem_rdata;
      PC_EX          <= PC_FETCH;
      valid_EX       <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_pipe.sv
// tb_fetch_pipe: directed and random checks of two fetch_pipe configurations against a behavioural model.
module tb_fetch_pipe;
  logic clk = 0;
  logic rst, stall;
  logic [1:0] src;
  logic [9:0] ba, ja, ra;
  logic [31:0] imem [1024];
  logic [9:0] a0, a1, pc0, pc1, pe0, pe1;
  logic [31:0] i0, i1;
  logic v0, v1;
  logic [15:0] sc0, rc0;
  logic [1:0] sc1, rc1;
  int n_chk = 0, n_fail = 0;
  logic [9:0] m_pc [2], m_pe [2];
  logic [31:0] m_ins [2];
  logic m_v [2];
  int m_sc [2], m_rc [2];
  int cmax [2] = '{65535, 3};
  int rpc [2] = '{0, 3};
  int ds [2] = '{0, 1};

  always #5 clk = ~clk;

  fetch_pipe #(.DELAY_SLOT(0)) dut0 (
    .clk(clk), .rst(rst), .stall_EX(stall), .pc_src_EX(src),
    .branch_addr_EX(ba), .jtype_addr_EX(ja), .reg_addr_EX(ra),
    .imem_addr(a0), .imem_rdata(imem[a0]), .PC_FETCH(pc0),
    .instruction_EX(i0), .PC_EX(pe0), .valid_EX(v0),
    .stall_count(sc0), .redirect_count(rc0));

  fetch_pipe #(.DELAY_SLOT(1), .CNT_WIDTH(2), .RESET_PC(3)) dut1 (
    .clk(clk), .rst(rst), .stall_EX(stall), .pc_src_EX(src),
    .branch_addr_EX(ba), .jtype_addr_EX(ja), .reg_addr_EX(ra),
    .imem_addr(a1), .imem_rdata(imem[a1]), .PC_FETCH(pc1),
    .instruction_EX(i1), .PC_EX(pe1), .valid_EX(v1),
    .stall_count(sc1), .redirect_count(rc1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pc[k] = 10'(rpc[k]); m_pe[k] = 0; m_ins[k] = 0; m_v[k] = 0; m_sc[k] = 0; m_rc[k] = 0;
      end else if (src != 0) begin
        m_ins[k] = ds[k] != 0 ? imem[m_pc[k]] : 32'h0;
        m_v[k] = ds[k] != 0;
        m_pe[k] = m_pc[k];
        m_pc[k] = src == 1 ? ba : src == 2 ? ja : ra;
        m_rc[k] = m_rc[k] < cmax[k] ? m_rc[k] + 1 : cmax[k];
      end else if (stall) begin
        m_sc[k] = m_sc[k] < cmax[k] ? m_sc[k] + 1 : cmax[k];
      end else begin
        m_ins[k] = imem[m_pc[k]]; m_v[k] = 1; m_pe[k] = m_pc[k];
        m_pc[k] = 10'((int'(m_pc[k]) + 1) % 1024);
      end
    end
  endtask

  task automatic check_all();
    chk("d0_pc", 32'(pc0), 32'(m_pc[0]));
    chk("d0_addr", 32'(a0), 32'(m_pc[0]));
    chk("d0_ins", i0, m_ins[0]);
    chk("d0_pcex", 32'(pe0), 32'(m_pe[0]));
    chk("d0_valid", 32'(v0), 32'(m_v[0]));
    chk("d0_stallcnt", 32'(sc0), 32'(m_sc[0]));
    chk("d0_redircnt", 32'(rc0), 32'(m_rc[0]));
    chk("d1_pc", 32'(pc1), 32'(m_pc[1]));
    chk("d1_addr", 32'(a1), 32'(m_pc[1]));
    chk("d1_ins", i1, m_ins[1]);
    chk("d1_pcex", 32'(pe1), 32'(m_pe[1]));
    chk("d1_valid", 32'(v1), 32'(m_v[1]));
    chk("d1_stallcnt", 32'(sc1), 32'(m_sc[1]));
    chk("d1_redircnt", 32'(rc1), 32'(m_rc[1]));
  endtask

  task automatic step(input logic r, input logic s, input logic [1:0] sr,
                      input logic [9:0] b, input logic [9:0] j, input logic [9:0] q);
    rst = r; stall = s; src = sr; ba = b; ja = j; ra = q;
    @(posedge clk);
    model();
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 32'h1000 + i;
    rst = 1; stall = 0; src = 0; ba = 0; ja = 0; ra = 0;
    #2;
    step(1, 0, 0, 0, 0, 0);
    chk("rst_pc", 32'(pc0), 0);
    chk("rst_valid", 32'(v0), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("free_ins", i0, 32'h1000 + i);
      chk("free_pcex", 32'(pe0), i);
      chk("free_valid", 32'(v0), 1);
    end
    chk("free_pc", 32'(pc0), 4);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0);
      chk("stall_pc", 32'(pc0), 5);
      chk("stall_ins", i0, 32'h1004);
      chk("stall_pcex", 32'(pe0), 4);
    end
    chk("stall_cnt", 32'(sc0), 3);
    step(0, 0, 0, 0, 0, 0);
    chk("resume_pcex", 32'(pe0), 5);
    chk("resume_ins", i0, 32'h1005);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("pre_br_pc", 32'(pc0), 8);
    step(0, 1, 2'b01, 10'h040, 0, 0);
    chk("br_pc", 32'(pc0), 32'h040);
    chk("br_valid", 32'(v0), 0);
    chk("br_ins", i0, 0);
    chk("br_rcnt", 32'(rc0), 1);
    chk("br_scnt", 32'(sc0), 3);
    step(0, 0, 2'b10, 0, 10'd8, 0);
    chk("jmp_pc", 32'(pc1), 8);
    step(0, 0, 2'b11, 0, 0, 10'h3F0);
    chk("ds_ins", i1, 32'h1008);
    chk("ds_pcex", 32'(pe1), 8);
    chk("ds_valid", 32'(v1), 1);
    chk("ds_pc", 32'(pc1), 32'h3F0);
    step(0, 0, 2'b11, 0, 0, 10'h3FF);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap_pc", 32'(pc0), 0);
    chk("wrap_pcex", 32'(pe0), 32'h3FF);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
    chk("sat_scnt", 32'(sc1), 3);
    chk("nosat_scnt", 32'(sc0), 5);
    step(1, 1, 2'b10, 0, 10'h155, 0);
    chk("rst_mid_pc0", 32'(pc0), 0);
    chk("rst_mid_pc1", 32'(pc1), 3);
    chk("rst_mid_scnt", 32'(sc0), 0);
    for (int i = 0; i < 1024; i++) imem[i] = $urandom;
    for (int i = 0; i < 400; i++) begin
      logic [1:0] s;
      logic [9:0] t;
      s = $urandom_range(0, 1) != 0 ? 2'($urandom) : 2'b00;
      t = $urandom_range(0, 3) == 0 ? m_pc[0] : 10'($urandom);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, s, t, t ^ 10'h2A5, 10'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_pipe.md
FETCH_PIPE -- requirements
Module: fetch_pipe

Interface
REQ-001 Parameter PC_WIDTH, default 10: width of the word-addressed program counter and all redirect targets.
REQ-002 Parameter INSTR_WIDTH, default 32: instruction width.
REQ-003 Parameter RESET_PC, default 0: PC_FETCH value loaded on reset.
REQ-004 Parameter DELAY_SLOT, default 0: 1 issues the instruction fetched in the redirect cycle (delay slot); 0 squashes it.
REQ-005 Parameter CNT_WIDTH, default 16: width of the stall and redirect event counters.
REQ-006 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-007 Port rst  input  1: reset, synchronous, active-high.
REQ-008 Port stall_EX  input  1: execute stage requests a hold.
REQ-009 Port pc_src_EX  input  2: next-PC select; 00 sequential, 01 branch, 10 jump, 11 register.
REQ-010 Ports branch_addr_EX, jtype_addr_EX, reg_addr_EX  input  PC_WIDTH each: redirect targets for pc_src_EX 01, 10, 11.
REQ-011 Port imem_addr  output  PC_WIDTH: instruction memory address; combinationally equal to PC_FETCH.
REQ-012 Port imem_rdata  input  INSTR_WIDTH: instruction memory read data, combinational from imem_addr.
REQ-013 Port PC_FETCH  output  PC_WIDTH: current fetch PC (register).
REQ-014 Port instruction_EX  output  INSTR_WIDTH: instruction register feeding execute.
REQ-015 Port PC_EX  output  PC_WIDTH: PC of instruction_EX.
REQ-016 Port valid_EX  output  1: instruction_EX is a real instruction, not a bubble.
REQ-017 Ports stall_count, redirect_count  output  CNT_WIDTH each: event counters.

Function
REQ-018 Each cycle exactly one action is taken, priority: rst > redirect (pc_src_EX != 00) > stall_EX > sequential.
REQ-019 Sequential: PC_FETCH <= PC_FETCH+1 modulo 2^PC_WIDTH; instruction_EX <= imem_rdata; PC_EX <= PC_FETCH; valid_EX <= 1.
REQ-020 Stall: PC_FETCH, instruction_EX, PC_EX, valid_EX all hold; stall_count increments.
REQ-021 Redirect: PC_FETCH <= target selected by pc_src_EX; redirect_count increments; stall_EX is ignored that cycle.
REQ-022 Redirect with DELAY_SLOT=1: instruction_EX <= imem_rdata, PC_EX <= PC_FETCH, valid_EX <= 1.
REQ-023 Redirect with DELAY_SLOT=0: instruction_EX <= 0 (NOP), PC_EX <= PC_FETCH, valid_EX <= 0.
REQ-024 PC wrap: all-ones PC_FETCH advances to 0 with no flag or stall.
REQ-025 Counters saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-026 Redirect to the current PC_FETCH is legal and behaves as any redirect.
REQ-027 Latency: instruction at address A appears on instruction_EX the cycle after PC_FETCH=A with a non-stall action.
REQ-028 No combinational path from stall_EX or pc_src_EX to any output.

Reset
REQ-029 rst high at a clock edge: PC_FETCH <= RESET_PC; instruction_EX <= 0; PC_EX <= 0; valid_EX <= 0; both counters <= 0.
REQ-030 rst overrides simultaneous redirect and stall, including mid-stall and mid-redirect.
REQ-031 First fetch occurs the cycle after rst deasserts, from RESET_PC.

Verification
REQ-032 Reset then 4 free cycles, imem[i]=0x1000+i, RESET_PC=0 -> instruction_EX 0x1000..0x1003, PC_EX 0..3, valid_EX=1, PC_FETCH=4.
REQ-033 PC_FETCH=5, stall_EX high 3 cycles -> PC_FETCH, instruction_EX, PC_EX frozen; stall_count=3; resume fetches address 5.
REQ-034 DELAY_SLOT=0, PC_FETCH=8, pc_src_EX=01, branch_addr_EX=0x040, stall_EX=1 -> next cycle PC_FETCH=0x040, valid_EX=0, instruction_EX=0, redirect_count=1, stall_count unchanged.
REQ-035 DELAY_SLOT=1, PC_FETCH=8, pc_src_EX=11, reg_addr_EX=0x3F0 -> instruction_EX=imem[8], PC_EX=8, valid_EX=1, PC_FETCH=0x3F0.
REQ-036 PC_FETCH=0x3FF sequential -> PC_FETCH=0, PC_EX=0x3FF; CNT_WIDTH=2, 5 stall cycles -> stall_count=3.
REQ-037 rst asserted during stall with pc_src_EX=10 -> all outputs at reset values next cycle; PC_FETCH=RESET_PC.
